// File: rtl/redirect_sequencer_pkg.sv
// rtl/redirect_sequencer_pkg.sv - shared encodings and helpers for the redirect sequencer
//
// Purpose:
//   State and source encodings shared by the sequencer top and its timer, plus
//   the timer width and a helper that turns a cycle count into a timer preload.
// Contents:
//   rs_state_e  : RS_IDLE / RS_FLUSH / RS_DRAIN / RS_REDIRECT
//   rs_src_e    : SRC_BP / SRC_JALR (winning redirect source)
//   TIMER_W     : width of the shared hold/drain down-counter
//   timer_load  : preload value so that the timer reaches zero on the Nth cycle

package redirect_sequencer_pkg;

  typedef enum logic [1:0] {
    RS_IDLE     = 2'd0,
    RS_FLUSH    = 2'd1,
    RS_DRAIN    = 2'd2,
    RS_REDIRECT = 2'd3
  } rs_state_e;

  typedef enum logic {
    SRC_BP   = 1'b0,
    SRC_JALR = 1'b1
  } rs_src_e;

  localparam int TIMER_W = 8;

  // A state that must last `count` cycles preloads count-1: the first cycle
  // sees count-1, the last cycle sees zero and takes the exit.
  function automatic logic [TIMER_W-1:0] timer_load(input int count);
    return TIMER_W'(count - 1);
  endfunction

endpackage

// File: rtl/redirect_sequencer_seq_timer.sv
// rtl/redirect_sequencer_seq_timer.sv - loadable saturating down-counter with zero flag
//
// Purpose:
//   Times both the flush hold window and the store-drain window. Load has
//   priority over decrement; the count saturates at zero.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   en         : global enable; low freezes the count
//   load       : preload count with load_val
//   load_val   : preload value
//   dec        : decrement by one (ignored at zero)
//   zero       : count currently equals zero

module redirect_sequencer_seq_timer
  import redirect_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/redirect_sequencer.sv
// rtl/redirect_sequencer.sv - flush / store-drain / redirect sequencing after a control-flow redirect
//
// Purpose:
//   Arbitrates branch-mispredict and JALR redirects, broadcasts a flush for
//   FLUSH_HOLD cycles, waits for committed stores to drain (bounded by
//   DRAIN_MAX), then issues one redirect pulse to IF. All outputs are flops.
// Parameters:
//   FLUSH_HOLD (1..7), DRAIN_MAX (1..255)
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global enable; low freezes state and outputs
//   bp_req/target   : predictor mispredict pulse and correct fetch address
//   jalr_req/target : ROB JALR redirect pulse and target (bit 0 clear)
//   lsb_store_busy  : committed store still in flight
//   flush_all       : flush strobe to all flushable units
//   redirect_valid  : one-cycle redirect pulse to IF
//   redirect_addr   : fetch address; holds until the next redirect
//   seq_busy        : high whenever a sequence is in progress (stalls commit)
//   drain_timeout   : sticky; drain window expired with a store still busy
// Build option:
//   REDIRECT_STATS_EN adds bp_flush_cnt, jalr_flush_cnt and drop_cnt outputs.

module redirect_sequencer
  import redirect_sequencer_pkg::*;
#(
  parameter int FLUSH_HOLD = 1,
  parameter int DRAIN_MAX  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        bp_req,
  input  logic [31:0] bp_target,
  input  logic        jalr_req,
  input  logic [31:0] jalr_target,
  input  logic        lsb_store_busy,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic        seq_busy,
  output logic        drain_timeout
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0] bp_flush_cnt,
  output logic [31:0] jalr_flush_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [TIMER_W-1:0] FLUSH_LOAD = timer_load(FLUSH_HOLD);
  localparam logic [TIMER_W-1:0] DRAIN_LOAD = timer_load(DRAIN_MAX);

  rs_state_e          state_q, state_d;
  rs_src_e            src_q, src_d;
  logic [31:0]        target_q, target_d;

  logic               flush_all_q, flush_all_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_addr_q, redirect_addr_d;
  logic               seq_busy_q, seq_busy_d;
  logic               drain_timeout_q, drain_timeout_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               tmr_dec;
  logic               tmr_zero;
  logic               timeout_set;
  logic [31:0]        issue_addr;

  redirect_sequencer_seq_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Sequencer FSM and arbiter. bp_req beats jalr_req: the JALR is younger
  // and is squashed by the flush anyway.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    target_d     = target_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    timeout_set  = 1'b0;

    case (state_q)
      RS_IDLE: begin
        if (bp_req || jalr_req) begin
          state_d      = RS_FLUSH;
          src_d        = bp_req ? SRC_BP : SRC_JALR;
          target_d     = bp_req ? bp_target : jalr_target;
          tmr_load     = 1'b1;
          tmr_load_val = FLUSH_LOAD;
        end
      end
      RS_FLUSH: begin
        if (tmr_zero) begin
          state_d      = RS_DRAIN;
          tmr_load     = 1'b1;
          tmr_load_val = DRAIN_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RS_DRAIN: begin
        // A store going idle always wins over an expiring window, so the
        // timeout flag only reports a genuinely stuck store.
        if (!lsb_store_busy) begin
          state_d = RS_REDIRECT;
        end else if (tmr_zero) begin
          state_d     = RS_REDIRECT;
          timeout_set = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RS_REDIRECT: begin
        state_d = RS_IDLE;
      end
      default: begin
        state_d = RS_IDLE;
      end
    endcase
  end

  // JALR targets arrive with bit 0 already clear; re-clearing keeps a
  // misbehaving producer from fetching a halfword-odd address.
  assign issue_addr = (src_q == SRC_JALR) ? {target_q[31:1], 1'b0} : target_q;

  // Outputs are decoded from the next state so they land in flops aligned
  // with the state they describe.
  always_comb begin
    flush_all_d      = (state_d == RS_FLUSH);
    redirect_valid_d = (state_d == RS_REDIRECT);
    seq_busy_d       = (state_d != RS_IDLE);
    drain_timeout_d  = drain_timeout_q | timeout_set;
    redirect_addr_d  = redirect_addr_q;
    if (state_d == RS_REDIRECT) begin
      redirect_addr_d = issue_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RS_IDLE;
      src_q            <= SRC_BP;
      target_q         <= '0;
      flush_all_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      seq_busy_q       <= 1'b0;
      drain_timeout_q  <= 1'b0;
    end else if (rdy) begin
      state_q          <= state_d;
      src_q            <= src_d;
      target_q         <= target_d;
      flush_all_q      <= flush_all_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      seq_busy_q       <= seq_busy_d;
      drain_timeout_q  <= drain_timeout_d;
    end
  end

  assign flush_all      = flush_all_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = redirect_addr_q;
  assign seq_busy       = seq_busy_q;
  assign drain_timeout  = drain_timeout_q;

`ifdef REDIRECT_STATS_EN
  logic [31:0] bp_flush_cnt_q, bp_flush_cnt_d;
  logic [31:0] jalr_flush_cnt_q, jalr_flush_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]  drop_inc;

  // Dropped requests: the arbitration loser in IDLE, or every request that
  // arrives while a sequence is already running.
  always_comb begin
    bp_flush_cnt_d   = bp_flush_cnt_q;
    jalr_flush_cnt_d = jalr_flush_cnt_q;
    if (state_q == RS_IDLE) begin
      drop_inc = {1'b0, bp_req & jalr_req};
    end else begin
      drop_inc = {1'b0, bp_req} + {1'b0, jalr_req};
    end
    if ((state_q == RS_IDLE) && (state_d == RS_FLUSH)) begin
      if (src_d == SRC_BP) begin
        bp_flush_cnt_d = bp_flush_cnt_q + 32'd1;
      end else begin
        jalr_flush_cnt_d = jalr_flush_cnt_q + 32'd1;
      end
    end
    drop_cnt_d = drop_cnt_q + 16'(drop_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_flush_cnt_q   <= '0;
      jalr_flush_cnt_q <= '0;
      drop_cnt_q       <= '0;
    end else if (rdy) begin
      bp_flush_cnt_q   <= bp_flush_cnt_d;
      jalr_flush_cnt_q <= jalr_flush_cnt_d;
      drop_cnt_q       <= drop_cnt_d;
    end
  end

  assign bp_flush_cnt   = bp_flush_cnt_q;
  assign jalr_flush_cnt = jalr_flush_cnt_q;
  assign drop_cnt       = drop_cnt_q;
`endif

endmodule

// File: tb/tb_redirect_sequencer.sv
// tb/tb_redirect_sequencer.sv - self-checking bench for redirect_sequencer
//
// Two instances share all inputs: dut0 (FLUSH_HOLD=1, DRAIN_MAX=64) and
// dut1 (FLUSH_HOLD=2, DRAIN_MAX=4). Each sequence is predicted from the
// timeline rules: flush for cycles 1..H, drain from H+1 until the store is
// idle or DRAIN_MAX cycles pass, redirect on the following cycle. rdy-low
// cycles stretch the timeline without advancing it.

module tb_redirect_sequencer;

  localparam int H0 = 1, DM0 = 64;
  localparam int H1 = 2, DM1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, bp_req, jalr_req, lsb_store_busy;
  logic [31:0] bp_target, jalr_target;
  logic        flush_all [2];
  logic        redirect_valid [2];
  logic        seq_busy [2];
  logic        drain_timeout [2];
  logic [31:0] redirect_addr [2];
`ifdef REDIRECT_STATS_EN
  logic [31:0] bp_flush_cnt [2];
  logic [31:0] jalr_flush_cnt [2];
  logic [15:0] drop_cnt [2];
`endif

  redirect_sequencer #(.FLUSH_HOLD(H0), .DRAIN_MAX(DM0)) dut0 (
    .clk(clk), .rst(rst), .rdy(rdy),
    .bp_req(bp_req), .bp_target(bp_target),
    .jalr_req(jalr_req), .jalr_target(jalr_target),
    .lsb_store_busy(lsb_store_busy),
    .flush_all(flush_all[0]), .redirect_valid(redirect_valid[0]),
    .redirect_addr(redirect_addr[0]), .seq_busy(seq_busy[0]),
    .drain_timeout(drain_timeout[0])
`ifdef REDIRECT_STATS_EN
    , .bp_flush_cnt(bp_flush_cnt[0]), .jalr_flush_cnt(jalr_flush_cnt[0]), .drop_cnt(drop_cnt[0])
`endif
  );

  redirect_sequencer #(.FLUSH_HOLD(H1), .DRAIN_MAX(DM1)) dut1 (
    .clk(clk), .rst(rst), .rdy(rdy),
    .bp_req(bp_req), .bp_target(bp_target),
    .jalr_req(jalr_req), .jalr_target(jalr_target),
    .lsb_store_busy(lsb_store_busy),
    .flush_all(flush_all[1]), .redirect_valid(redirect_valid[1]),
    .redirect_addr(redirect_addr[1]), .seq_busy(seq_busy[1]),
    .drain_timeout(drain_timeout[1])
`ifdef REDIRECT_STATS_EN
    , .bp_flush_cnt(bp_flush_cnt[1]), .jalr_flush_cnt(jalr_flush_cnt[1]), .drop_cnt(drop_cnt[1])
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [2:0]  obs [2][0:127];
  int          effk [0:127];
  int          nrec;

  logic [31:0] exp_addr [2];
  bit          exp_to [2];
  logic [31:0] exp_bp, exp_jr;
  logic [15:0] exp_drop;

  function automatic int hold_of(input int d);
    return (d == 0) ? H0 : H1;
  endfunction

  function automatic int dmax_of(input int d);
    return (d == 0) ? DM0 : DM1;
  endfunction

  // Store busy for effective cycles 0..bu-1. Drain occupies cycles h+1..e,
  // where e is the first cycle with the store idle, capped at h+dm.
  function automatic int redirect_cycle(input int h, input int dm, input int bu);
    int e;
    e = (bu > h + 1) ? bu : h + 1;
    if (e > h + dm) e = h + dm;
    return e + 1;
  endfunction

  function automatic bit times_out(input int h, input int dm, input int bu);
    return bu > h + dm;
  endfunction

  // {flush_all, redirect_valid, seq_busy} at effective cycle e
  function automatic logic [2:0] exp_out(input int e, input int h, input int r);
    return {(e >= 1 && e <= h), (e == r), (e >= 1 && e <= r)};
  endfunction

  task automatic model_apply(input bit b, input bit j, input logic [31:0] tb_t,
                             input logic [31:0] tj_t, input int bu, input bit stray);
    for (int d = 0; d < 2; d++) begin
      exp_addr[d] = b ? tb_t : tj_t;
      if (times_out(hold_of(d), dmax_of(d), bu)) exp_to[d] = 1'b1;
    end
    if (b) exp_bp = exp_bp + 32'd1;
    else   exp_jr = exp_jr + 32'd1;
    exp_drop = exp_drop + ((b && j) ? 16'd1 : 16'd0) + (stray ? 16'd2 : 16'd0);
  endtask

  // Drives one request at cycle 0 and records outputs for cycles 1..nrec.
  // Frozen cycles also raise both requests, which must be ignored.
  task automatic run_seq(input bit b, input bit j, input logic [31:0] tb_t,
                         input logic [31:0] tj_t, input int bu, input bit stray,
                         input int frz_at, input int frz_len, input int rst_at);
    int eff;
    int rmax;
    rmax = redirect_cycle(H0, DM0, bu);
    if (redirect_cycle(H1, DM1, bu) > rmax) rmax = redirect_cycle(H1, DM1, bu);
    nrec = rmax + frz_len + 3;
    @(posedge clk); #1;
    rdy = 1'b1; rst = 1'b0;
    bp_req = b; jalr_req = j; bp_target = tb_t; jalr_target = tj_t;
    lsb_store_busy = (0 < bu);
    eff = 1;
    for (int k = 1; k <= nrec; k++) begin
      bit frz;
      @(posedge clk); #1;
      frz = (frz_len > 0) && (k >= frz_at) && (k < frz_at + frz_len);
      effk[k] = eff;
      rdy = !frz;
      rst = (k == rst_at);
      bp_req = (stray && k == 2) || frz;
      jalr_req = (stray && k == 2) || frz;
      bp_target = $urandom;
      jalr_target = $urandom & 32'hffff_fffe;
      lsb_store_busy = (eff < bu);
      if (!frz) eff++;
      @(negedge clk);
      for (int d = 0; d < 2; d++) obs[d][k] = {flush_all[d], redirect_valid[d], seq_busy[d]};
    end
    @(posedge clk); #1;
    rdy = 1'b1; rst = 1'b0; bp_req = 1'b0; jalr_req = 1'b0; lsb_store_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; bp_req = 1'b1; jalr_req = 1'b1; lsb_store_busy = 1'b1;
    bp_target = 32'h1234_5678; jalr_target = 32'h8765_4320;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({flush_all[d], redirect_valid[d], seq_busy[d], drain_timeout[d], redirect_addr[d]} !== 36'd0) begin
        errors++;
        $display("FAIL reset dut%0d flush=%b rv=%b busy=%b to=%b addr=%h expected all 0",
                 d, flush_all[d], redirect_valid[d], seq_busy[d], drain_timeout[d], redirect_addr[d]);
      end
`ifdef REDIRECT_STATS_EN
      checks++;
      if ({bp_flush_cnt[d], jalr_flush_cnt[d], drop_cnt[d]} !== 80'd0) begin
        errors++;
        $display("FAIL reset_stats dut%0d got %0d %0d %0d expected 0 0 0",
                 d, bp_flush_cnt[d], jalr_flush_cnt[d], drop_cnt[d]);
      end
`endif
    end
    @(posedge clk); #1;
    rst = 1'b0; bp_req = 1'b0; jalr_req = 1'b0; lsb_store_busy = 1'b0;
  endtask

  // 0: basic bp latency, 1: same-cycle arbitration, 2: drain wait,
  // 3: stuck store (dut1 times out), 4: rdy freeze during drain.
  task automatic test_directed();
    bit b, j;
    logic [31:0] tb_t, tj_t;
    int bu, fa, fl;
    for (int t = 0; t < 5; t++) begin
      fa = 0; fl = 0;
      case (t)
        0: begin b = 1; j = 0; tb_t = 32'h0000_1040; tj_t = 32'h0;         bu = 0;  end
        1: begin b = 1; j = 1; tb_t = 32'h0000_0200; tj_t = 32'h0000_0300; bu = 0;  end
        2: begin b = 0; j = 1; tb_t = 32'h0;         tj_t = 32'h0000_2468; bu = 7;  end
        3: begin b = 1; j = 0; tb_t = 32'hdead_beef; tj_t = 32'h0;         bu = 40; end
        default: begin b = 0; j = 1; tb_t = 32'h0; tj_t = 32'h0000_8000; bu = 6; fa = 4; fl = 3; end
      endcase
      run_seq(b, j, tb_t, tj_t, bu, 1'b0, fa, fl, -1);
      model_apply(b, j, tb_t, tj_t, bu, 1'b0);
      for (int k = 1; k <= nrec; k++) begin
        for (int d = 0; d < 2; d++) begin
          logic [2:0] ex;
          ex = exp_out(effk[k], hold_of(d), redirect_cycle(hold_of(d), dmax_of(d), bu));
          checks++;
          if (obs[d][k] !== ex) begin
            errors++;
            $display("FAIL dir%0d dut%0d cycle %0d {flush,rv,busy} got %b expected %b", t, d, k, obs[d][k], ex);
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (redirect_addr[d] !== exp_addr[d]) begin
          errors++;
          $display("FAIL dir%0d_addr dut%0d got %h expected %h", t, d, redirect_addr[d], exp_addr[d]);
        end
        checks++;
        if (drain_timeout[d] !== exp_to[d]) begin
          errors++;
          $display("FAIL dir%0d_timeout dut%0d got %b expected %b", t, d, drain_timeout[d], exp_to[d]);
        end
`ifdef REDIRECT_STATS_EN
        checks++;
        if ({bp_flush_cnt[d], jalr_flush_cnt[d], drop_cnt[d]} !== {exp_bp, exp_jr, exp_drop}) begin
          errors++;
          $display("FAIL dir%0d_stats dut%0d got %0d %0d %0d expected %0d %0d %0d", t, d,
                   bp_flush_cnt[d], jalr_flush_cnt[d], drop_cnt[d], exp_bp, exp_jr, exp_drop);
        end
`endif
      end
    end
  endtask

  task automatic test_rst_mid();
    run_seq(1'b1, 1'b0, 32'h4444_0000, 32'h0, 0, 1'b0, 0, 0, 2);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d][1] !== 3'b101) begin
        errors++;
        $display("FAIL rst_mid_flush dut%0d cycle 1 got %b expected 101", d, obs[d][1]);
      end
      for (int k = 3; k <= nrec; k++) begin
        checks++;
        if (obs[d][k] !== 3'b000) begin
          errors++;
          $display("FAIL rst_mid_idle dut%0d cycle %0d got %b expected 000", d, k, obs[d][k]);
        end
      end
      checks++;
      if ({drain_timeout[d], redirect_addr[d]} !== 33'd0) begin
        errors++;
        $display("FAIL rst_mid_regs dut%0d to=%b addr=%h expected 0 0", d, drain_timeout[d], redirect_addr[d]);
      end
      exp_addr[d] = 32'h0;
      exp_to[d] = 1'b0;
    end
    exp_bp = 32'h0; exp_jr = 32'h0; exp_drop = 16'h0;
`ifdef REDIRECT_STATS_EN
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({bp_flush_cnt[d], jalr_flush_cnt[d], drop_cnt[d]} !== 80'd0) begin
        errors++;
        $display("FAIL rst_mid_stats dut%0d got %0d %0d %0d expected 0 0 0",
                 d, bp_flush_cnt[d], jalr_flush_cnt[d], drop_cnt[d]);
      end
    end
`endif
    run_seq(1'b1, 1'b0, 32'h0000_5550, 32'h0, 0, 1'b0, 0, 0, -1);
    model_apply(1'b1, 1'b0, 32'h0000_5550, 32'h0, 0, 1'b0);
    for (int k = 1; k <= nrec; k++) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0] ex;
        ex = exp_out(effk[k], hold_of(d), redirect_cycle(hold_of(d), dmax_of(d), 0));
        checks++;
        if (obs[d][k] !== ex) begin
          errors++;
          $display("FAIL rst_mid_rerun dut%0d cycle %0d got %b expected %b", d, k, obs[d][k], ex);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (redirect_addr[d] !== exp_addr[d]) begin
        errors++;
        $display("FAIL rst_mid_rerun_addr dut%0d got %h expected %h", d, redirect_addr[d], exp_addr[d]);
      end
    end
  endtask

  task automatic test_random();
    bit b, j, stray;
    logic [31:0] tb_t, tj_t;
    int bu, fa, fl, sel;
    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(0, 2);
      b = (sel != 1);
      j = (sel != 0);
      tb_t = $urandom;
      tj_t = $urandom & 32'hffff_fffe;
      bu = $urandom_range(0, 9);
      stray = $urandom_range(0, 1) == 1;
      fa = 0; fl = 0;
      if ($urandom_range(0, 3) == 0) begin
        fa = $urandom_range(3, 5);
        fl = $urandom_range(1, 3);
      end
      run_seq(b, j, tb_t, tj_t, bu, stray, fa, fl, -1);
      model_apply(b, j, tb_t, tj_t, bu, stray);
      for (int k = 1; k <= nrec; k++) begin
        for (int d = 0; d < 2; d++) begin
          logic [2:0] ex;
          ex = exp_out(effk[k], hold_of(d), redirect_cycle(hold_of(d), dmax_of(d), bu));
          checks++;
          if (obs[d][k] !== ex) begin
            errors++;
            $display("FAIL rand%0d dut%0d cycle %0d {flush,rv,busy} got %b expected %b", it, d, k, obs[d][k], ex);
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (redirect_addr[d] !== exp_addr[d] || drain_timeout[d] !== exp_to[d]) begin
          errors++;
          $display("FAIL rand%0d_end dut%0d addr %h to %b expected addr %h to %b", it, d,
                   redirect_addr[d], drain_timeout[d], exp_addr[d], exp_to[d]);
        end
`ifdef REDIRECT_STATS_EN
        checks++;
        if ({bp_flush_cnt[d], jalr_flush_cnt[d], drop_cnt[d]} !== {exp_bp, exp_jr, exp_drop}) begin
          errors++;
          $display("FAIL rand%0d_stats dut%0d got %0d %0d %0d expected %0d %0d %0d", it, d,
                   bp_flush_cnt[d], jalr_flush_cnt[d], drop_cnt[d], exp_bp, exp_jr, exp_drop);
        end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; bp_req = 1'b0; jalr_req = 1'b0; lsb_store_busy = 1'b0;
    bp_target = 32'h0; jalr_target = 32'h0;
    for (int d = 0; d < 2; d++) begin
      exp_addr[d] = 32'h0;
      exp_to[d] = 1'b0;
    end
    exp_bp = 32'h0; exp_jr = 32'h0; exp_drop = 16'h0;
    test_reset();
    test_directed();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
